// File: rtl/id_ex_pipeline_register_if.sv
// Decode-to-execute boundary bus: decoded fields in, registered execute fields out,
// plus the hazard request and the load-use bubble counter.
interface id_ex_pipeline_register_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stallIn;
    logic                  flush;
    logic                  idValid;
    logic [XLEN-1:0]       idPc;
    logic [XLEN-1:0]       idRs1Data;
    logic [XLEN-1:0]       idRs2Data;
    logic [XLEN-1:0]       idImm;
    logic [REG_ADDR_W-1:0] idRs1Addr;
    logic [REG_ADDR_W-1:0] idRs2Addr;
    logic [REG_ADDR_W-1:0] idRdAddr;
    logic                  idUsesRs1;
    logic                  idUsesRs2;
    logic [2:0]            idFunct3;
    logic                  idFunct7b5;
    logic                  idBranchEnable;
    logic                  idMemoryReadEnable;
    logic                  idMemoryWriteEnable;
    logic                  idRegisterWriteEnable;
    logic                  idPcAdderSrc;
    logic                  idWriteBackFromMemoryOrAlu;
    logic [1:0]            idAluSrc1;
    logic [1:0]            idAluSrc2;
    logic [2:0]            idAluOperation;

    logic [XLEN-1:0]       exPc;
    logic [XLEN-1:0]       exRs1Data;
    logic [XLEN-1:0]       exRs2Data;
    logic [XLEN-1:0]       exImm;
    logic [REG_ADDR_W-1:0] exRs1Addr;
    logic [REG_ADDR_W-1:0] exRs2Addr;
    logic [REG_ADDR_W-1:0] exRdAddr;
    logic [2:0]            exFunct3;
    logic                  exFunct7b5;
    logic                  exBranchEnable;
    logic                  exMemoryReadEnable;
    logic                  exMemoryWriteEnable;
    logic                  exRegisterWriteEnable;
    logic                  exPcAdderSrc;
    logic                  exWriteBackFromMemoryOrAlu;
    logic [1:0]            exAluSrc1;
    logic [1:0]            exAluSrc2;
    logic [2:0]            exAluOperation;
    logic                  exValid;
    logic                  hazardStall;
    logic [31:0]           bubbleCount;

    modport master (
        output stallIn, flush, idValid, idPc, idRs1Data, idRs2Data, idImm,
               idRs1Addr, idRs2Addr, idRdAddr, idUsesRs1, idUsesRs2, idFunct3, idFunct7b5,
               idBranchEnable, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable,
               idPcAdderSrc, idWriteBackFromMemoryOrAlu, idAluSrc1, idAluSrc2, idAluOperation,
        input  exPc, exRs1Data, exRs2Data, exImm, exRs1Addr, exRs2Addr, exRdAddr, exFunct3,
               exFunct7b5, exBranchEnable, exMemoryReadEnable, exMemoryWriteEnable,
               exRegisterWriteEnable, exPcAdderSrc, exWriteBackFromMemoryOrAlu, exAluSrc1,
               exAluSrc2, exAluOperation, exValid, hazardStall, bubbleCount
    );

    modport slave (
        input  stallIn, flush, idValid, idPc, idRs1Data, idRs2Data, idImm,
               idRs1Addr, idRs2Addr, idRdAddr, idUsesRs1, idUsesRs2, idFunct3, idFunct7b5,
               idBranchEnable, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable,
               idPcAdderSrc, idWriteBackFromMemoryOrAlu, idAluSrc1, idAluSrc2, idAluOperation,
        output exPc, exRs1Data, exRs2Data, exImm, exRs1Addr, exRs2Addr, exRdAddr, exFunct3,
               exFunct7b5, exBranchEnable, exMemoryReadEnable, exMemoryWriteEnable,
               exRegisterWriteEnable, exPcAdderSrc, exWriteBackFromMemoryOrAlu, exAluSrc1,
               exAluSrc2, exAluOperation, exValid, hazardStall, bubbleCount
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall and bubble insertion.
// Optional load-use bubble counter enabled by macro ID_EX_PERF_COUNT_EN.
module id_ex_pipeline_register #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic                     clk,
    input logic                     rstN,
    id_ex_pipeline_register_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1Data;
        logic [XLEN-1:0]       rs2Data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1Addr;
        logic [REG_ADDR_W-1:0] rs2Addr;
        logic [REG_ADDR_W-1:0] rdAddr;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic                  branchEnable;
        logic                  memoryReadEnable;
        logic                  memoryWriteEnable;
        logic                  registerWriteEnable;
        logic                  pcAdderSrc;
        logic                  writeBackFromMemoryOrAlu;
        logic [1:0]            aluSrc1;
        logic [1:0]            aluSrc2;
        logic [2:0]            aluOperation;
    } stage_t;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    stage_t idStage_s;
    stage_t exNext_s;
    stage_t exStage_r;
    logic   exValidNext_s;
    logic   exValid_r;
    logic   loadUse_s;

    assign idStage_s = '{
        pc:                       bus.idPc,
        rs1Data:                  bus.idRs1Data,
        rs2Data:                  bus.idRs2Data,
        imm:                      bus.idImm,
        rs1Addr:                  bus.idRs1Addr,
        rs2Addr:                  bus.idRs2Addr,
        rdAddr:                   bus.idRdAddr,
        funct3:                   bus.idFunct3,
        funct7b5:                 bus.idFunct7b5,
        branchEnable:             bus.idBranchEnable,
        memoryReadEnable:         bus.idMemoryReadEnable,
        memoryWriteEnable:        bus.idMemoryWriteEnable,
        registerWriteEnable:      bus.idRegisterWriteEnable,
        pcAdderSrc:               bus.idPcAdderSrc,
        writeBackFromMemoryOrAlu: bus.idWriteBackFromMemoryOrAlu,
        aluSrc1:                  bus.idAluSrc1,
        aluSrc2:                  bus.idAluSrc2,
        aluOperation:             bus.idAluOperation
    };

    // A load in EX whose nonzero destination feeds a source the decoded instruction reads.
    always_comb begin
        loadUse_s = exValid_r & exStage_r.memoryReadEnable & (exStage_r.rdAddr != REG_X0)
                  & bus.idValid
                  & ((bus.idUsesRs1 & (bus.idRs1Addr == exStage_r.rdAddr))
                   | (bus.idUsesRs2 & (bus.idRs2Addr == exStage_r.rdAddr)));
    end

    assign bus.hazardStall = loadUse_s & ~bus.flush;

    // Next-stage selection: flush beats stall; bubbles zero the whole bundle so X never leaks.
    always_comb begin
        exNext_s      = exStage_r;
        exValidNext_s = exValid_r;
        if (bus.flush) begin
            exNext_s      = '0;
            exValidNext_s = 1'b0;
        end else if (bus.stallIn) begin
            exNext_s      = exStage_r;
            exValidNext_s = exValid_r;
        end else if (loadUse_s || !bus.idValid) begin
            exNext_s      = '0;
            exValidNext_s = 1'b0;
        end else begin
            exNext_s      = idStage_s;
            exValidNext_s = 1'b1;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            exStage_r <= '0;
            exValid_r <= 1'b0;
        end else begin
            exStage_r <= exNext_s;
            exValid_r <= exValidNext_s;
        end
    end

`ifdef ID_EX_PERF_COUNT_EN
    logic        countBubble_s;
    logic [31:0] bubbleCount_r;

    assign countBubble_s = loadUse_s & ~bus.flush & ~bus.stallIn;

    // Saturating count of load-use bubbles only.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bubbleCount_r <= 32'd0;
        end else if (countBubble_s && (bubbleCount_r != 32'hFFFF_FFFF)) begin
            bubbleCount_r <= bubbleCount_r + 32'd1;
        end else begin
            bubbleCount_r <= bubbleCount_r;
        end
    end

    assign bus.bubbleCount = bubbleCount_r;
`else
    assign bus.bubbleCount = 32'd0;
`endif

    assign bus.exPc                       = exStage_r.pc;
    assign bus.exRs1Data                  = exStage_r.rs1Data;
    assign bus.exRs2Data                  = exStage_r.rs2Data;
    assign bus.exImm                      = exStage_r.imm;
    assign bus.exRs1Addr                  = exStage_r.rs1Addr;
    assign bus.exRs2Addr                  = exStage_r.rs2Addr;
    assign bus.exRdAddr                   = exStage_r.rdAddr;
    assign bus.exFunct3                   = exStage_r.funct3;
    assign bus.exFunct7b5                 = exStage_r.funct7b5;
    assign bus.exBranchEnable             = exStage_r.branchEnable;
    assign bus.exMemoryReadEnable         = exStage_r.memoryReadEnable;
    assign bus.exMemoryWriteEnable        = exStage_r.memoryWriteEnable;
    assign bus.exRegisterWriteEnable      = exStage_r.registerWriteEnable;
    assign bus.exPcAdderSrc               = exStage_r.pcAdderSrc;
    assign bus.exWriteBackFromMemoryOrAlu = exStage_r.writeBackFromMemoryOrAlu;
    assign bus.exAluSrc1                  = exStage_r.aluSrc1;
    assign bus.exAluSrc2                  = exStage_r.aluSrc2;
    assign bus.exAluOperation             = exStage_r.aluOperation;
    assign bus.exValid                    = exValid_r;
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed vector table, hand-written corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_id_ex_pipeline_register;
    logic clk  = 1'b0;
    logic rstN = 1'b1;

    id_ex_pipeline_register_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    id_ex_pipeline_register #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rstN(rstN), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [4:0]  rdAddr;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        branchEnable;
        logic        memoryReadEnable;
        logic        memoryWriteEnable;
        logic        registerWriteEnable;
        logic        pcAdderSrc;
        logic        writeBackFromMemoryOrAlu;
        logic [1:0]  aluSrc1;
        logic [1:0]  aluSrc2;
        logic [2:0]  aluOperation;
    } stage_t;

    typedef struct packed {
        stage_t      id;
        logic        v;
        logic        u1;
        logic        u2;
        logic        fl;
        logic        eHaz;
        logic        eValid;
        logic        eRegWr;
        logic        eMemRd;
        logic [31:0] ePc;
        logic [2:0]  eAluOp;
    } vec_t;

    int          total  = 0;
    int          passed = 0;
    stage_t      mEx    = '0;
    logic        mValid = 1'b0;
    logic [31:0] mCount = 32'd0;
    stage_t      curId  = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic stage_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic memRd, input logic memWr,
                                  input logic regWr, input logic [2:0] aluOp);
        stage_t s;
        s                          = '0;
        s.pc                       = pc;
        s.rs1Data                  = 32'h1000_0000 ^ pc;
        s.rs2Data                  = 32'h2000_0000 ^ pc;
        s.imm                      = 32'hFFFF_FFF0 ^ pc;
        s.rs1Addr                  = rs1;
        s.rs2Addr                  = rs2;
        s.rdAddr                   = rd;
        s.funct3                   = pc[4:2];
        s.memoryReadEnable         = memRd;
        s.memoryWriteEnable        = memWr;
        s.registerWriteEnable      = regWr;
        s.writeBackFromMemoryOrAlu = memRd;
        s.aluSrc1                  = 2'b01;
        s.aluSrc2                  = (memRd | memWr) ? 2'b10 : 2'b00;
        s.aluOperation             = aluOp;
        return s;
    endfunction

    task automatic driveId(input stage_t s, input logic v, input logic u1, input logic u2,
                           input logic st, input logic fl);
        curId                          = s;
        bus.idPc                       = s.pc;
        bus.idRs1Data                  = s.rs1Data;
        bus.idRs2Data                  = s.rs2Data;
        bus.idImm                      = s.imm;
        bus.idRs1Addr                  = s.rs1Addr;
        bus.idRs2Addr                  = s.rs2Addr;
        bus.idRdAddr                   = s.rdAddr;
        bus.idFunct3                   = s.funct3;
        bus.idFunct7b5                 = s.funct7b5;
        bus.idBranchEnable             = s.branchEnable;
        bus.idMemoryReadEnable         = s.memoryReadEnable;
        bus.idMemoryWriteEnable        = s.memoryWriteEnable;
        bus.idRegisterWriteEnable      = s.registerWriteEnable;
        bus.idPcAdderSrc               = s.pcAdderSrc;
        bus.idWriteBackFromMemoryOrAlu = s.writeBackFromMemoryOrAlu;
        bus.idAluSrc1                  = s.aluSrc1;
        bus.idAluSrc2                  = s.aluSrc2;
        bus.idAluOperation             = s.aluOperation;
        bus.idValid                    = v;
        bus.idUsesRs1                  = u1;
        bus.idUsesRs2                  = u2;
        bus.stallIn                    = st;
        bus.flush                      = fl;
    endtask

    task automatic sampleEx(output stage_t s);
        s.pc                       = bus.exPc;
        s.rs1Data                  = bus.exRs1Data;
        s.rs2Data                  = bus.exRs2Data;
        s.imm                      = bus.exImm;
        s.rs1Addr                  = bus.exRs1Addr;
        s.rs2Addr                  = bus.exRs2Addr;
        s.rdAddr                   = bus.exRdAddr;
        s.funct3                   = bus.exFunct3;
        s.funct7b5                 = bus.exFunct7b5;
        s.branchEnable             = bus.exBranchEnable;
        s.memoryReadEnable         = bus.exMemoryReadEnable;
        s.memoryWriteEnable        = bus.exMemoryWriteEnable;
        s.registerWriteEnable      = bus.exRegisterWriteEnable;
        s.pcAdderSrc               = bus.exPcAdderSrc;
        s.writeBackFromMemoryOrAlu = bus.exWriteBackFromMemoryOrAlu;
        s.aluSrc1                  = bus.exAluSrc1;
        s.aluSrc2                  = bus.exAluSrc2;
        s.aluOperation             = bus.exAluOperation;
    endtask

    // Reference rule: the instruction in EX is a real load to a nonzero register the decoded one reads.
    function automatic logic modelLoadUse();
        if (!mValid || !mEx.memoryReadEnable || mEx.rdAddr == 5'd0 || bus.idValid !== 1'b1) return 1'b0;
        return (bus.idUsesRs1 && bus.idRs1Addr == mEx.rdAddr) || (bus.idUsesRs2 && bus.idRs2Addr == mEx.rdAddr);
    endfunction

    // One clock: check the hazard before the edge, advance the model, check the stage after it.
    task automatic cycle(input string name);
        stage_t      nx;
        stage_t      act;
        logic        nv;
        logic [31:0] nc;
        logic        lu;
        @(negedge clk);
        lu = modelLoadUse();
        check({name, " hazardStall"}, {255'd0, bus.hazardStall}, {255'd0, lu & ~bus.flush});
        nx = mEx;
        nv = mValid;
        nc = mCount;
        if (bus.flush || (!bus.stallIn && (lu || !bus.idValid))) begin
            nx = '0;
            nv = 1'b0;
        end else if (!bus.stallIn) begin
            nx = curId;
            nv = 1'b1;
        end
`ifdef ID_EX_PERF_COUNT_EN
        if (!bus.flush && !bus.stallIn && lu && nc != 32'hFFFF_FFFF) nc = nc + 32'd1;
`endif
        @(posedge clk);
        #1;
        mEx    = nx;
        mValid = nv;
        mCount = nc;
        sampleEx(act);
        check({name, " ex"}, {96'd0, act}, {96'd0, mEx});
        check({name, " exValid"}, {255'd0, bus.exValid}, {255'd0, mValid});
        check({name, " bubbleCount"}, {224'd0, bus.bubbleCount}, {224'd0, mCount});
    endtask

    task automatic doReset(input string name);
        stage_t act;
        rstN = 1'b0;
        #1;
        mEx    = '0;
        mValid = 1'b0;
        mCount = 32'd0;
        sampleEx(act);
        check({name, " ex"}, {96'd0, act}, 256'd0);
        check({name, " exValid"}, {255'd0, bus.exValid}, 256'd0);
        check({name, " bubbleCount"}, {224'd0, bus.bubbleCount}, 256'd0);
        check({name, " hazardStall"}, {255'd0, bus.hazardStall}, 256'd0);
        driveId('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs [9];
        stage_t      act;
        stage_t      snap;
        stage_t      dep;
        stage_t      ld;
        logic [31:0] cnt;

        driveId('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        doReset("reset");

        vecs[0] = '{mk(32'h10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 3'b010};
        vecs[1] = '{mk(32'h14, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 3'b000};
        vecs[2] = '{mk(32'h18, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000};
        vecs[3] = '{mk(32'h18, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 32'h18, 3'b010};
        vecs[4] = '{mk(32'h1c, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 32'h1c, 3'b000};
        vecs[5] = '{mk(32'h20, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 3'b010};
        vecs[6] = '{mk(32'h24, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b000), 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 3'b000};
        vecs[7] = '{mk(32'h28, 5'd1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000), 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000};
        vecs[8] = '{mk(32'h2c, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 3'b010), 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000};

        for (int i = 0; i < 9; i++) begin
            driveId(vecs[i].id, vecs[i].v, vecs[i].u1, vecs[i].u2, 1'b0, vecs[i].fl);
            #2;
            check($sformatf("vec%0d hazard", i), {255'd0, bus.hazardStall}, {255'd0, vecs[i].eHaz});
            cycle($sformatf("vec%0d model", i));
            check($sformatf("vec%0d exValid", i), {255'd0, bus.exValid}, {255'd0, vecs[i].eValid});
            check($sformatf("vec%0d regWr", i), {255'd0, bus.exRegisterWriteEnable}, {255'd0, vecs[i].eRegWr});
            check($sformatf("vec%0d memRd", i), {255'd0, bus.exMemoryReadEnable}, {255'd0, vecs[i].eMemRd});
            check($sformatf("vec%0d exPc", i), {224'd0, bus.exPc}, {224'd0, vecs[i].ePc});
            check($sformatf("vec%0d aluOp", i), {253'd0, bus.exAluOperation}, {253'd0, vecs[i].eAluOp});
        end

        // Stall holds everything for three cycles while decode changes underneath.
        snap = mk(32'h40, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 3'b011);
        driveId(snap, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("stallLoad");
        for (int i = 0; i < 3; i++) begin
            driveId(mk(32'h44 + 32'(i * 4), 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 1'b1, 3'b001), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle("stallHold");
            sampleEx(act);
            check($sformatf("stall%0d held", i), {96'd0, act}, {96'd0, snap});
            check($sformatf("stall%0d exValid", i), {255'd0, bus.exValid}, 256'd1);
        end

        // Flush wins over stall on the same edge.
        driveId(mk(32'h50, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 3'b010), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("stallFlush");
        check("stallFlush exValid", {255'd0, bus.exValid}, 256'd0);
        check("stallFlush regWr", {255'd0, bus.exRegisterWriteEnable}, 256'd0);

        // Load-use under stall: hazard held, no bubble counted until the stall releases.
        ld  = mk(32'h60, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 3'b000);
        dep = mk(32'h64, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 3'b010);
        driveId(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("luLoad");
        cnt = bus.bubbleCount;
        for (int i = 0; i < 2; i++) begin
            driveId(dep, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            #2;
            check($sformatf("luStall%0d hazard", i), {255'd0, bus.hazardStall}, 256'd1);
            cycle("luStall");
            check($sformatf("luStall%0d exPc", i), {224'd0, bus.exPc}, {224'd0, 32'h60});
            check($sformatf("luStall%0d count", i), {224'd0, bus.bubbleCount}, {224'd0, cnt});
        end
        driveId(dep, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("luBubble");
        check("luBubble exValid", {255'd0, bus.exValid}, 256'd0);
        check("luBubble memRd", {255'd0, bus.exMemoryReadEnable}, 256'd0);
`ifdef ID_EX_PERF_COUNT_EN
        check("luBubble count", {224'd0, bus.bubbleCount}, {224'd0, cnt + 32'd1});
`else
        check("luBubble count", {224'd0, bus.bubbleCount}, 256'd0);
`endif
        #2;
        check("luAfter hazard", {255'd0, bus.hazardStall}, 256'd0);
        cycle("luCapture");
        check("luCapture exPc", {224'd0, bus.exPc}, {224'd0, 32'h64});

        // Invalid instruction with unknown controls must leave a clean bubble.
        driveId('x, 1'b0, 1'bx, 1'bx, 1'b0, 1'b0);
        curId = '0;
        cycle("invalid");
        sampleEx(act);
        check("invalid noX", {96'd0, act}, 256'd0);
        check("invalid exValid", {255'd0, bus.exValid}, 256'd0);

        // Reset while a load-use hazard is being requested.
        driveId(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("rstLoad");
        driveId(mk(32'h68, 5'd2, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 3'b000), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("rstPre hazard", {255'd0, bus.hazardStall}, 256'd1);
        doReset("midHazardReset");

        // Randomized traffic with a small register pool so dependences are frequent.
        for (int i = 0; i < 400; i++) begin
            driveId(mk($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7))),
                    ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            cycle("rnd");
        end

`ifdef ID_EX_PERF_COUNT_EN
        // Saturation: preload near the top, then three load-use bubbles.
        driveId('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("satIdle");
        force dut.bubbleCount_r = 32'hFFFF_FFFE;
        #1;
        release dut.bubbleCount_r;
        mCount = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            driveId(ld, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle("satLoad");
            driveId(dep, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            cycle("satBubble");
        end
        check("saturated count", {224'd0, bus.bubbleCount}, {224'd0, 32'hFFFF_FFFF});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline boundary. Latches the decoded control bundle, operands, immediate and register addresses into a single registered stage that feeds execute.
- Contains the load-use hazard detector. It requests a fetch/decode hold and inserts a bubble into execute.
- Handles external stall, branch flush and invalid (undecodable) instructions.

Parameters:
XLEN, 32, datapath width for pc, register data and immediate
REG_ADDR_W, 5, register-file address width

Ports:
clk  input  1  core clock, rising edge
rstN  input  1  asynchronous active-low reset
stallIn  input  1  downstream freeze (memory wait); hold all contents
flush  input  1  branch/jump redirect; kill the instruction entering EX
idValid  input  1  decode slot holds a real instruction
idPc  input  XLEN  pc of decoded instruction
idRs1Data  input  XLEN  register-file read data 1
idRs2Data  input  XLEN  register-file read data 2
idImm  input  XLEN  sign-extended immediate
idRs1Addr  input  REG_ADDR_W  source 1 address
idRs2Addr  input  REG_ADDR_W  source 2 address
idRdAddr  input  REG_ADDR_W  destination address
idUsesRs1  input  1  instruction reads rs1
idUsesRs2  input  1  instruction reads rs2
idFunct3  input  3  funct3 field
idFunct7b5  input  1  funct7 bit 5
idBranchEnable, idMemoryReadEnable, idMemoryWriteEnable, idRegisterWriteEnable, idPcAdderSrc, idWriteBackFromMemoryOrAlu  input  1 each  decode control
idAluSrc1, idAluSrc2  input  2 each  operand selects
idAluOperation  input  3  ALU class
ex* (one per id* data/control field above except idUses*)  output  same widths  registered copies
exValid  output  1  EX slot holds a real instruction
hazardStall  output  1  hold PC and IF/ID register this cycle
bubbleCount  output  32  load-use bubble counter (see Optional Feature)

Behaviour:
- Reset (rstN=0, asynchronous): every ex* output = 0, exValid=0, bubbleCount=0. Effect is immediate, regardless of clk.
- Load-use condition (combinational): loadUse = exValid & exMemoryReadEnable & (exRdAddr!=0) & idValid & ((idUsesRs1 & idRs1Addr==exRdAddr) | (idUsesRs2 & idRs2Addr==exRdAddr)).
- hazardStall = loadUse & ~flush.
- Per-edge update, priority highest first:
  1. flush=1: capture bubble, even if stallIn=1.
  2. stallIn=1: hold every register unchanged, including exValid.
  3. loadUse=1: capture bubble.
  4. idValid=0: capture bubble. Decode control may be X here and must not propagate.
  5. Otherwise: capture all id* fields, exValid=1.
- Bubble: exValid=0. All ex* control and data fields = 0, so memory write, register write and branch are disabled.
- Latency: 1 cycle from id* to ex*.
- Load-use produces exactly one bubble. On the next cycle exMemoryReadEnable=0, so hazardStall drops.
- Under stallIn with loadUse: hazardStall stays asserted and no bubble is counted until stallIn releases.
- rd=x0 never triggers a hazard.
- Reset asserted mid-stall or mid-hazard clears all state. hazardStall=0 after reset because exValid=0.

Optional Feature:
- Macro: ID_EX_PERF_COUNT_EN.
- With macro: bubbleCount increments by 1 on every edge where rule 3 (load-use bubble) applies. It saturates at 32'hFFFF_FFFF and is cleared only by reset. Flush and invalid-instruction bubbles are not counted.
- Without macro: counter logic is absent and bubbleCount is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset then normal flow: assert rstN=0 mid-cycle -> all ex* = 0 immediately. Release, drive ADD x3,x1,x2 (idValid=1, RType controls, pc=0x10) -> next edge exRegisterWriteEnable=1, exAluOperation=3'b010, exPc=0x10, exValid=1.
- Load-use: LW x5 in EX, ID instruction uses rs1=x5 -> hazardStall=1 for one cycle, EX gets bubble (exValid=0, all enables 0). Following edge captures the dependent instruction; bubbleCount=1 with macro, 0 without.
- x0 destination: LW x0 in EX, ID uses rs1=x0 -> hazardStall=0, no bubble.
- Flush vs stall: stallIn=1 and flush=1 on the same edge -> bubble captured, exValid=0. stallIn=1 alone for 3 cycles -> all ex* unchanged.
- Invalid instruction: idValid=0 with X on all decode controls -> exValid=0, no X on any ex* output.
- Counter saturation (macro on): force bubbleCount near 32'hFFFF_FFFE, apply 3 load-use bubbles -> holds at 32'hFFFF_FFFF.
